count_capture: RTL and testbench
================================

# count_capture

Timestamp/compare stage directly downstream of the free-running `counter`: samples its `count` output every cycle, detects terminal-count wrap, extends the time base with a wrap counter, raises a compare-match pulse against a programmable value, and captures `{wrap_cnt, count}` snapshots on request into a one-entry valid/ready buffer. The block gives the rest of the design a wider event timebase without widening the counter itself.

## Interface
- `WIDTH`, 4: width of `count_in`; must equal the upstream counter `WIDTH`.
- `EVT_W`, 8: width of the wrap counter.

- `clk`  in  1  clock, same domain as upstream counter.
- `rst`  in  1  reset, asynchronous, active-high.
- `count_in`  in  WIDTH  upstream counter value.
- `cmp_wr`  in  1  load strobe for compare register.
- `cmp_val`  in  WIDTH  compare value, sampled when `cmp_wr`=1.
- `cap_trig`  in  1  capture request, one-cycle pulse per request.
- `cap_ready`  in  1  consumer accepts `cap_data`.
- `match`  out  1  registered one-cycle compare-match pulse.
- `wrap`  out  1  registered one-cycle wrap pulse.
- `wrap_cnt`  out  EVT_W  wraps seen since reset, modulo 2^EVT_W.
- `cap_valid`  out  1  capture buffer holds data.
- `cap_data`  out  EVT_W+WIDTH  `{wrap_cnt, count}` snapshot.
- `cap_ovf`  out  1  sticky: a capture was dropped.

## Operation
- Internal regs: `prev_count`, `prev_valid`, `cmp_reg`, capture FSM.
- `prev_valid` is 0 after reset; set on first clk edge after release; `prev_count` <= `count_in` every cycle.
- Wrap detect (comb, `wrap_det`): `prev_valid` && `prev_count`=all-ones && `count_in`=0. A jump to 0 from any other value (upstream reset) is not a wrap.
- `wrap_cnt` increments on `wrap_det`; rolls over from all-ones to 0 silently.
- Match detect: `count_in`=`cmp_reg` && (`count_in`!=`prev_count` || !`prev_valid`); a held count matches once only.
- `cmp_wr`: `cmp_reg` <= `cmp_val`; affects comparisons from the next cycle on. Same-cycle compare uses old `cmp_reg`.
- Capture snapshot value: `{wrap_cnt + wrap_det, count_in}`, i.e. a wrap in the trigger cycle is included, so data is consistent with `count_in`=0.
- Capture FSM, states EMPTY, FULL:
  - EMPTY: `cap_trig` -> load snapshot, go FULL.
  - FULL: `cap_ready` && !`cap_trig` -> go EMPTY.
  - FULL: `cap_ready` && `cap_trig` -> load new snapshot, stay FULL, no overflow.
  - FULL: !`cap_ready` && `cap_trig` -> drop request, keep old data, set `cap_ovf`.
- `cap_ovf` clears on the clock edge of the next accepted handshake (`cap_valid`&&`cap_ready`), unless a drop happens in that same cycle (set wins).
- `cap_data` is stable while `cap_valid`=1 and `cap_ready`=0.

## Timing
- Reset values: `match`=0, `wrap`=0, `wrap_cnt`=0, `cap_valid`=0, `cap_data`=0, `cap_ovf`=0, `cmp_reg`=0, `prev_count`=0, `prev_valid`=0.
- `match`, `wrap`: asserted the cycle after `count_in` is sampled (latency 1), high exactly one cycle; `wrap_cnt` updates on the same edge as `wrap` rises.
- `cap_valid` rises 1 cycle after `cap_trig`; handshake completes on the edge where `cap_valid`&&`cap_ready`.
- Reset mid-operation: all state returns to reset values immediately; buffered capture is discarded, no handshake.
- First sample after reset with `cmp_reg`=0 and `count_in`=0 produces one `match`.

## Structure
- Package `count_capture_pkg`: capture FSM state typedef (`CAP_EMPTY`, `CAP_FULL`).
- Sub-module `count_event_detect`: `prev_count`/`prev_valid`, wrap and match detection, `wrap_cnt`; top holds `cmp_reg` and capture FSM.

## Test plan
- Reset release, upstream counts 0..15,0 (WIDTH=4) -> single `wrap` pulse one cycle after `count_in`=0 sampled; `wrap_cnt`=1.
- `cmp_wr` with `cmp_val`=5, then count runs -> `match` high one cycle after `count_in`=5 each lap, nowhere else; count held at 5 for 3 cycles -> one pulse.
- `wrap_cnt`=2, `cap_trig` at `count_in`=7, `cap_ready`=0 -> `cap_valid`=1, `cap_data`={8'd2,4'd7}, stable until `cap_ready`=1, then `cap_valid`=0.
- `cap_trig` in the cycle `count_in` goes 15->0 with `wrap_cnt`=0 -> `cap_data`={8'd1,4'd0}.
- Buffer FULL, `cap_ready`=0, second `cap_trig` -> data unchanged, `cap_ovf`=1; handshake -> `cap_ovf`=0 next cycle; FULL with `cap_ready`&&`cap_trig` -> new data, `cap_ovf` stays 0.
- Assert `rst` while FULL and `wrap_cnt`=3 -> all outputs 0 immediately; upstream restart from 0 produces no `wrap`.

Source files
------------

// File: rtl/count_capture_pkg.sv
// count_capture_pkg
// Shared types for the count_capture timestamp stage.
//   cap_state_t : one-entry capture buffer state (CAP_EMPTY / CAP_FULL).
package count_capture_pkg;

  typedef enum logic [0:0] {
    CAP_EMPTY = 1'b0,
    CAP_FULL  = 1'b1
  } cap_state_t;

endpackage : count_capture_pkg

// File: rtl/count_event_detect.sv
// count_event_detect
// Watches the upstream counter value, detects terminal-count wraps and
// compare matches, and extends the timebase with a wrap counter.
// Ports:
//   clk, rst      : clock, asynchronous active-high reset
//   count_in      : upstream counter value
//   cmp_reg       : current compare value (held by the parent)
//   wrap_det      : combinational wrap indication for the current sample
//   match         : registered one-cycle compare-match pulse
//   wrap          : registered one-cycle wrap pulse
//   wrap_cnt      : wraps seen since reset, modulo 2^EVT_W
module count_event_detect #(
  parameter int WIDTH = 4,
  parameter int EVT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] count_in,
  input  logic [WIDTH-1:0] cmp_reg,
  output logic             wrap_det,
  output logic             match,
  output logic             wrap,
  output logic [EVT_W-1:0] wrap_cnt
);

  logic [WIDTH-1:0] prev_count_reg;
  logic             prev_valid_reg;
  logic             match_det;
  logic             match_reg;
  logic             wrap_reg;
  logic [EVT_W-1:0] wrap_cnt_reg;

  // Only an all-ones -> zero step is a wrap; a jump to zero from any other
  // value is an upstream reset and must not advance the timebase.
  assign wrap_det = prev_valid_reg && (prev_count_reg == {WIDTH{1'b1}})
                    && (count_in == '0);

  // A count held at the compare value matches only on the cycle it arrives.
  // The very first sample after reset has no history, so it may match.
  assign match_det = (count_in == cmp_reg)
                     && ((count_in != prev_count_reg) || !prev_valid_reg);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_count_reg <= '0;
      prev_valid_reg <= 1'b0;
      match_reg      <= 1'b0;
      wrap_reg       <= 1'b0;
      wrap_cnt_reg   <= '0;
    end else begin
      prev_count_reg <= count_in;
      prev_valid_reg <= 1'b1;
      match_reg      <= match_det;
      wrap_reg       <= wrap_det;
      if (wrap_det) begin
        wrap_cnt_reg <= wrap_cnt_reg + 1'b1;
      end
    end
  end

  assign match    = match_reg;
  assign wrap     = wrap_reg;
  assign wrap_cnt = wrap_cnt_reg;

endmodule : count_event_detect

// File: rtl/count_capture.sv
// count_capture
// Timestamp/compare stage behind the free-running counter. Extends the
// counter with a wrap count, pulses on compare match, and captures
// {wrap_cnt, count} snapshots into a one-entry valid/ready buffer.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   count_in   : upstream counter value
//   cmp_wr     : load strobe for the compare register
//   cmp_val    : compare value, taken when cmp_wr=1
//   cap_trig   : capture request (one-cycle pulse)
//   cap_ready  : consumer accepts cap_data
//   match      : one-cycle compare-match pulse
//   wrap       : one-cycle wrap pulse
//   wrap_cnt   : wraps since reset
//   cap_valid  : capture buffer holds data
//   cap_data   : {wrap_cnt, count} snapshot
//   cap_ovf    : sticky flag, a capture request was dropped
module count_capture
  import count_capture_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int EVT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WIDTH-1:0]       count_in,
  input  logic                   cmp_wr,
  input  logic [WIDTH-1:0]       cmp_val,
  input  logic                   cap_trig,
  input  logic                   cap_ready,
  output logic                   match,
  output logic                   wrap,
  output logic [EVT_W-1:0]       wrap_cnt,
  output logic                   cap_valid,
  output logic [EVT_W+WIDTH-1:0] cap_data,
  output logic                   cap_ovf
);

  logic [WIDTH-1:0]       cmp_reg;
  cap_state_t             state_reg;
  cap_state_t             state_next;
  logic [EVT_W+WIDTH-1:0] cap_data_reg;
  logic                   cap_ovf_reg;
  logic                   wrap_det;
  logic                   accept;
  logic                   load;
  logic                   drop;
  logic [EVT_W+WIDTH-1:0] snapshot;

  count_event_detect #(
    .WIDTH (WIDTH),
    .EVT_W (EVT_W)
  ) u_detect (
    .clk      (clk),
    .rst      (rst),
    .count_in (count_in),
    .cmp_reg  (cmp_reg),
    .wrap_det (wrap_det),
    .match    (match),
    .wrap     (wrap),
    .wrap_cnt (wrap_cnt)
  );

  // Fold a wrap happening in the trigger cycle into the snapshot so the
  // wrap count is consistent with count_in having just returned to zero.
  assign snapshot = {wrap_cnt + EVT_W'(wrap_det), count_in};

  assign accept = (state_reg == CAP_FULL) && cap_ready;
  // A request is taken when the buffer is empty or is being drained in the
  // same cycle; otherwise it is dropped and the held data stays untouched.
  assign load   = cap_trig && ((state_reg == CAP_EMPTY) || cap_ready);
  assign drop   = cap_trig && (state_reg == CAP_FULL) && !cap_ready;

  always_comb begin
    state_next = state_reg;
    if (load) begin
      state_next = CAP_FULL;
    end else if (accept) begin
      state_next = CAP_EMPTY;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmp_reg      <= '0;
      state_reg    <= CAP_EMPTY;
      cap_data_reg <= '0;
      cap_ovf_reg  <= 1'b0;
    end else begin
      if (cmp_wr) begin
        cmp_reg <= cmp_val;
      end
      state_reg <= state_next;
      if (load) begin
        cap_data_reg <= snapshot;
      end
      // Set wins over the clear from a handshake in the same cycle.
      if (drop) begin
        cap_ovf_reg <= 1'b1;
      end else if (accept) begin
        cap_ovf_reg <= 1'b0;
      end
    end
  end

  assign cap_valid = (state_reg == CAP_FULL);
  assign cap_data  = cap_data_reg;
  assign cap_ovf   = cap_ovf_reg;

endmodule : count_capture

// File: tb/tb_count_capture.sv
// tb_count_capture
// Self-checking bench for count_capture (WIDTH=4, EVT_W=8): a hand-computed
// vector table, hand-written reset sequences, and randomized counter
// traffic compared against a behavioural model.
module tb_count_capture;

  logic        clk;
  logic        rst;
  logic [3:0]  count_in;
  logic        cmp_wr;
  logic [3:0]  cmp_val;
  logic        cap_trig;
  logic        cap_ready;
  logic        match;
  logic        wrap;
  logic [7:0]  wrap_cnt;
  logic        cap_valid;
  logic [11:0] cap_data;
  logic        cap_ovf;

  int tests_run = 0;
  int tests_failed = 0;

  count_capture #(.WIDTH(4), .EVT_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .count_in  (count_in),
    .cmp_wr    (cmp_wr),
    .cmp_val   (cmp_val),
    .cap_trig  (cap_trig),
    .cap_ready (cap_ready),
    .match     (match),
    .wrap      (wrap),
    .wrap_cnt  (wrap_cnt),
    .cap_valid (cap_valid),
    .cap_data  (cap_data),
    .cap_ovf   (cap_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int          m_prev;
  bit          m_prev_valid;
  int          m_cmp;
  int          m_wraps;
  logic [11:0] m_buf[$];
  bit          m_ovf;
  bit          m_match;
  bit          m_wrap;
  bit          m_accepted;

  function automatic void model_reset();
    m_prev = 0; m_prev_valid = 0; m_cmp = 0; m_wraps = 0;
    m_buf.delete(); m_ovf = 0; m_match = 0; m_wrap = 0; m_accepted = 0;
  endfunction

  function automatic void model_step(int cnt, bit wr, int val, bit trig, bit rdy);
    bit wrapped;
    bit dropped;
    logic [11:0] snap;
    wrapped = m_prev_valid && (m_prev == 15) && (cnt == 0);
    m_match = (cnt == m_cmp) && (!m_prev_valid || cnt != m_prev);
    m_wrap  = wrapped;
    snap    = {8'((m_wraps + int'(wrapped)) % 256), 4'(cnt)};
    m_accepted = (m_buf.size() == 1) && rdy;
    dropped = 0;
    if (m_accepted) m_buf.delete();
    if (trig) begin
      if (m_buf.size() == 0) m_buf.push_back(snap);
      else dropped = 1;
    end
    if (dropped) m_ovf = 1;
    else if (m_accepted) m_ovf = 0;
    m_wraps = (m_wraps + int'(wrapped)) % 256;
    m_prev = cnt;
    m_prev_valid = 1;
    if (wr) m_cmp = val;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // One clock: the model sees the inputs present at the edge.
  task automatic tick();
    @(posedge clk);
    model_step(int'(count_in), cmp_wr, int'(cmp_val), cap_trig, cap_ready);
    #1;
  endtask

  task automatic check_model();
    chk("match", 32'(match), 32'(m_match));
    chk("wrap", 32'(wrap), 32'(m_wrap));
    chk("wrap_cnt", 32'(wrap_cnt), 32'(m_wraps));
    chk("cap_valid", 32'(cap_valid), 32'(m_buf.size()));
    chk("cap_ovf", 32'(cap_ovf), 32'(m_ovf));
    if (m_buf.size() == 1) chk("cap_data", 32'(cap_data), 32'(m_buf[0]));
  endtask

  task automatic drive(input int cnt, input bit wr, input int val, input bit trig, input bit rdy);
    count_in = 4'(cnt); cmp_wr = wr; cmp_val = 4'(val); cap_trig = trig; cap_ready = rdy;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_match"}, 32'(match), 0);
    chk({tag, "_wrap"}, 32'(wrap), 0);
    chk({tag, "_wrap_cnt"}, 32'(wrap_cnt), 0);
    chk({tag, "_cap_valid"}, 32'(cap_valid), 0);
    chk({tag, "_cap_data"}, 32'(cap_data), 0);
    chk({tag, "_cap_ovf"}, 32'(cap_ovf), 0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    int          cnt;
    bit          wr;
    int          val;
    bit          trig;
    bit          rdy;
    bit          e_match;
    bit          e_wrap;
    int          e_wcnt;
    bit          e_valid;
    logic [11:0] e_data;
    bit          e_ovf;
  } vec_t;

  vec_t vecs[15];

  initial begin
    // cnt wr val trig rdy | match wrap wcnt valid data ovf
    vecs[0]  = '{14, 1, 5, 0, 0, 0, 0, 0, 0, 12'h000, 0};
    vecs[1]  = '{15, 0, 0, 0, 0, 0, 0, 0, 0, 12'h000, 0};
    vecs[2]  = '{0,  0, 0, 1, 0, 0, 1, 1, 1, 12'h010, 0}; // trig on wrap
    vecs[3]  = '{1,  0, 0, 1, 0, 0, 0, 1, 1, 12'h010, 1}; // dropped
    vecs[4]  = '{2,  0, 0, 0, 1, 0, 0, 1, 0, 12'h000, 0}; // handshake clears ovf
    vecs[5]  = '{3,  0, 0, 1, 0, 0, 0, 1, 1, 12'h013, 0};
    vecs[6]  = '{4,  0, 0, 1, 1, 0, 0, 1, 1, 12'h014, 0}; // drain + reload
    vecs[7]  = '{5,  0, 0, 0, 0, 1, 0, 1, 1, 12'h014, 0}; // match at 5
    vecs[8]  = '{5,  0, 0, 0, 0, 0, 0, 1, 1, 12'h014, 0}; // held: no match
    vecs[9]  = '{5,  0, 0, 1, 0, 0, 0, 1, 1, 12'h014, 1}; // held + drop
    vecs[10] = '{6,  0, 0, 1, 1, 0, 0, 1, 1, 12'h016, 0}; // reload, ovf clear
    vecs[11] = '{0,  0, 0, 0, 1, 0, 0, 1, 0, 12'h000, 0}; // 6->0 not a wrap
    vecs[12] = '{5,  1, 8, 0, 0, 1, 0, 1, 0, 12'h000, 0}; // old cmp used
    vecs[13] = '{8,  0, 0, 0, 0, 1, 0, 1, 0, 12'h000, 0}; // new cmp
    vecs[14] = '{9,  0, 0, 0, 0, 0, 0, 1, 0, 12'h000, 0};
  end

  // ---------------- stimulus ----------------
  initial begin
    int cnt_drv;
    int r;
    int n_acc;
    drive(0, 0, 0, 0, 0);
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Table vectors.
    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].cnt, vecs[i].wr, vecs[i].val, vecs[i].trig, vecs[i].rdy);
      tick();
      $display("[TB] vec %0d cnt=%0d trig=%0d rdy=%0d -> match=%0d wrap=%0d wcnt=%0d valid=%0d data=%03h ovf=%0d",
               i, vecs[i].cnt, vecs[i].trig, vecs[i].rdy, match, wrap, wrap_cnt, cap_valid, cap_data, cap_ovf);
      chk("tbl_match", 32'(match), 32'(vecs[i].e_match));
      chk("tbl_wrap", 32'(wrap), 32'(vecs[i].e_wrap));
      chk("tbl_wrap_cnt", 32'(wrap_cnt), 32'(vecs[i].e_wcnt));
      chk("tbl_cap_valid", 32'(cap_valid), 32'(vecs[i].e_valid));
      chk("tbl_cap_ovf", 32'(cap_ovf), 32'(vecs[i].e_ovf));
      if (vecs[i].e_valid) chk("tbl_cap_data", 32'(cap_data), 32'(vecs[i].e_data));
    end

    // Reset mid-operation: three laps (wrap_cnt=3), buffer FULL, then rst.
    drive(0, 0, 0, 0, 0);
    @(negedge clk);
    rst = 1'b1;
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    for (int lap = 0; lap < 3; lap++) begin
      for (int c = 0; c < 16; c++) begin
        drive(c, 0, 0, 0, 0);
        tick();
        check_model();
      end
    end
    drive(0, 0, 0, 0, 0);
    tick();
    check_model();
    chk("three_laps_wrap_cnt", 32'(wrap_cnt), 3);
    drive(1, 0, 0, 1, 0);
    tick();
    check_model();
    chk("full_before_rst", 32'(cap_valid), 1);
    drive(2, 0, 0, 0, 0);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all_zero("async_rst");
    @(posedge clk);
    #1;
    rst = 1'b0;
    // Upstream restarts from 0: no wrap, one first-sample match (cmp_reg=0).
    drive(0, 0, 0, 0, 0);
    tick();
    check_model();
    chk("restart_match", 32'(match), 1);
    chk("restart_wrap", 32'(wrap), 0);
    for (int c = 1; c < 4; c++) begin
      drive(c, 0, 0, 0, 0);
      tick();
      check_model();
    end

    // Randomized traffic against the model.
    cnt_drv = 4;
    n_acc = 0;
    for (int cyc = 0; cyc < 6000; cyc++) begin
      r = int'($urandom_range(0, 99));
      if (r < 80)      cnt_drv = (cnt_drv + 1) % 16;
      else if (r < 88) cnt_drv = cnt_drv;
      else if (r < 93) cnt_drv = 0;
      else             cnt_drv = int'($urandom_range(0, 15));
      drive(cnt_drv, ($urandom_range(0, 99) < 5), int'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 20), ($urandom_range(0, 1) == 1));
      tick();
      check_model();
      if (m_accepted) begin
        n_acc++;
        if (n_acc <= 40) $display("[TB] rand cyc %0d capture accepted", cyc);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule : tb_count_capture
